// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, rw codes,
// and the per-size mask of low address bits that must be zero for an aligned access.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_BEAT0 = 2'b10,
        S_BEAT1 = 2'b11
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic [1:0] align_mask(size_e sz);
        case (sz)
            SZ_BYTE: return 2'b00;
            SZ_HALF: return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage requester (master) and the responder (slave).
// Single-shot handshake on req_valid/req_ready; responses are pulses with no back-pressure.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_wdata_hi;
    logic        resp_valid;
    logic        resp_last;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_rw, req_size, req_addr, req_wdata, req_wdata_hi,
        input  req_ready, resp_valid, resp_last, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_rw, req_size, req_addr, req_wdata, req_wdata_hi,
        output req_ready, resp_valid, resp_last, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/data_mem_responder_lane_mux.sv
// Combinational big-endian lane steering: lane i is byte address base+i, lane 0 is the MSB.
// Reads zero-extend B/H; writes place right-justified data on lanes with matching enables.
module data_mem_responder_lane_mux
    import data_mem_responder_pkg::*;
(
    input  size_e           i_size,
    input  logic [3:0][7:0] i_rd_bytes,
    input  logic [31:0]     i_wdata,
    output logic [31:0]     o_rdata,
    output logic [3:0]      o_be,
    output logic [3:0][7:0] o_wr_bytes
);

    always_comb begin
        o_rdata    = '0;
        o_be       = '0;
        o_wr_bytes = '0;
        case (i_size)
            SZ_BYTE: begin
                o_rdata       = {24'h0, i_rd_bytes[0]};
                o_be          = 4'b0001;
                o_wr_bytes[0] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_rdata       = {16'h0, i_rd_bytes[0], i_rd_bytes[1]};
                o_be          = 4'b0011;
                o_wr_bytes[0] = i_wdata[15:8];
                o_wr_bytes[1] = i_wdata[7:0];
            end
            default: begin
                // Word and each doubleword beat move a full 32-bit word.
                o_rdata       = {i_rd_bytes[0], i_rd_bytes[1], i_rd_bytes[2], i_rd_bytes[3]};
                o_be          = 4'b1111;
                o_wr_bytes[0] = i_wdata[31:24];
                o_wr_bytes[1] = i_wdata[23:16];
                o_wr_bytes[2] = i_wdata[15:8];
                o_wr_bytes[3] = i_wdata[7:0];
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: first beat 1+WAIT_STATES cycles after accept, DW adds a second beat;
// no response back-pressure, one request in flight. DMEM_ALIGN_CHECK_EN selects error vs align-down.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
)(
    input logic                 CLK,
    input logic                 CLR,
    data_mem_responder_if.slave bus
);

    logic [7:0] Mem [0:2**ADDR_W-1];

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_wcnt, w_wcnt_nxt;
    logic              r_rw;
    size_e             r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_wdata_hi;
    logic              r_err;

    size_e             w_req_size;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_req_err;
    logic              w_accept;
    logic              w_beat;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [ADDR_W-1:0] w_lane_addr [4];
    logic [3:0][7:0]   w_rd_bytes;
    logic [31:0]       w_beat_wdata;
    logic [31:0]       w_rdata;
    logic [3:0]        w_be;
    logic [3:0][7:0]   w_wr_bytes;
    logic              w_unused;

    assign w_req_size = size_e'(bus.req_size);
    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_unused   = ^bus.req_addr[31:ADDR_W];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_req_addr = bus.req_addr[ADDR_W-1:0];
    assign w_req_err  = |(bus.req_addr[1:0] & align_mask(w_req_size));
`else
    assign w_req_addr = bus.req_addr[ADDR_W-1:0] & ~ADDR_W'(align_mask(w_req_size));
    assign w_req_err  = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_rw       <= RW_READ;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wdata_hi <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_rw       <= bus.req_rw;
                r_size     <= w_req_size;
                r_addr     <= w_req_addr;
                r_wdata    <= bus.req_wdata;
                r_wdata_hi <= bus.req_wdata_hi;
                r_err      <= w_req_err;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_BEAT0;
                end
            end
            S_WAIT: begin
                if (r_wcnt == 4'(WAIT_STATES - 1)) begin
                    w_wcnt_nxt  = '0;
                    w_state_nxt = S_BEAT0;
                end else begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                end
            end
            S_BEAT0: w_state_nxt = (r_size == SZ_DWORD) ? S_BEAT1 : S_IDLE;
            S_BEAT1: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Every lane address wraps modulo the array depth, including the DW +4 beat.
    assign w_beat       = (r_state == S_BEAT0) || (r_state == S_BEAT1);
    assign w_beat_addr  = (r_state == S_BEAT1) ? r_addr + ADDR_W'(4) : r_addr;
    assign w_beat_wdata = (r_state == S_BEAT1) ? r_wdata_hi : r_wdata;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_addr[g] = w_beat_addr + ADDR_W'(g);
        assign w_rd_bytes[g]  = Mem[w_lane_addr[g]];
    end

    data_mem_responder_lane_mux u_lane_mux (
        .i_size     (r_size),
        .i_rd_bytes (w_rd_bytes),
        .i_wdata    (w_beat_wdata),
        .o_rdata    (w_rdata),
        .o_be       (w_be),
        .o_wr_bytes (w_wr_bytes)
    );

    // Array is deliberately outside reset so its contents survive CLR.
    always_ff @(posedge CLK) begin
        if (w_beat && (r_rw == RW_WRITE) && !r_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) Mem[w_lane_addr[i]] <= w_wr_bytes[i];
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.resp_valid = w_beat;
    assign bus.resp_last  = (r_state == S_BEAT1) || ((r_state == S_BEAT0) && (r_size != SZ_DWORD));
    assign bus.resp_err   = w_beat && r_err;
    assign bus.resp_rdata = (w_beat && (r_rw == RW_READ) && !r_err) ? w_rdata : 32'h0;

endmodule
